// File: rtl/fifo_rd_packer.sv
// Read-side packer: pops RATIO FIFO words into one wide word.
// Flush emits a partial word with its lane count.
module fifo_rd_packer #(
  parameter  int DSIZE = 8,
  parameter  int RATIO = 4,
  localparam int CW    = $clog2(RATIO + 1)
) (
  input  logic                   rclk,
  input  logic                   rrst,
  input  logic                   rempty,
  input  logic [DSIZE-1:0]       rdata,
  output logic                   rinc,
  input  logic                   flush,
  output logic                   o_valid,
  input  logic                   o_ready,
  output logic [DSIZE*RATIO-1:0] o_data,
  output logic [CW-1:0]          o_cnt
);

  localparam int OW = DSIZE * RATIO;
  localparam logic [CW-1:0] LAST = CW'(RATIO - 1);
  localparam logic [CW-1:0] FULL = CW'(RATIO);

  typedef enum logic {ACCUM, FLUSH} state_t;

  state_t         state, state_n;
  logic [CW-1:0]  cnt, cnt_n;
  logic [OW-1:0]  acc, acc_n;
  logic           flush_pend, flush_pend_n;
  logic           valid_n;
  logic [OW-1:0]  data_n;
  logic [CW-1:0]  ocnt_n;
  logic           out_free;
  logic           pop;

  assign out_free = !o_valid || o_ready;
  assign rinc     = pop;

  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    acc_n        = acc;
    flush_pend_n = flush_pend || flush;
    valid_n      = o_valid && !o_ready;
    data_n       = o_data;
    ocnt_n       = o_cnt;
    pop          = 1'b0;
    unique case (state)
      ACCUM: begin
        // The completing pop needs the output register free.
        pop = !rrst && !rempty && !flush_pend &&
              !(cnt == LAST && !out_free);
        if (pop) begin
          if (cnt == LAST) begin
            data_n = acc;
            data_n[(RATIO-1)*DSIZE +: DSIZE] = rdata;
            ocnt_n  = FULL;
            valid_n = 1'b1;
            cnt_n   = '0;
            acc_n   = '0;
          end else begin
            acc_n[int'(cnt)*DSIZE +: DSIZE] = rdata;
            cnt_n = cnt + CW'(1);
          end
        end
        if (flush_pend)
          state_n = FLUSH;
      end
      FLUSH: begin
        if (cnt == '0) begin
          flush_pend_n = 1'b0;
          state_n      = ACCUM;
        end else if (out_free) begin
          data_n       = acc;
          ocnt_n       = cnt;
          valid_n      = 1'b1;
          cnt_n        = '0;
          acc_n        = '0;
          flush_pend_n = 1'b0;
          state_n      = ACCUM;
        end
      end
    endcase
  end

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      state      <= ACCUM;
      cnt        <= '0;
      acc        <= '0;
      flush_pend <= 1'b0;
      o_valid    <= 1'b0;
      o_data     <= '0;
      o_cnt      <= '0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      acc        <= acc_n;
      flush_pend <= flush_pend_n;
      o_valid    <= valid_n;
      o_data     <= data_n;
      o_cnt      <= ocnt_n;
    end
  end

endmodule

// File: doc/fifo_rd_packer.md
Name: fifo_rd_packer

Overview:
- Read-side consumer of the async FIFO, in the read clock domain.
- Pops DSIZE-bit words via rinc/rempty/rdata and packs RATIO consecutive words into one output word.
- Presents each packed word on a registered valid/ready output interface.
- A flush request emits a partially filled word with a lane count, so trailing data is never stranded.

Parameters:
- DSIZE, 8, width of one FIFO word.
- RATIO, 4, FIFO words per packed output word; legal range is RATIO >= 2.
- CW, $clog2(RATIO+1), width of o_cnt (derived, not overridden).

Ports:
- rclk  input  1  read-domain clock, all logic on the rising edge.
- rrst  input  1  asynchronous, active-high reset.
- rempty  input  1  FIFO empty flag.
- rdata  input  DSIZE  FIFO head word; valid whenever rempty=0 (show-ahead).
- rinc  output  1  pop strobe to FIFO; head is consumed on an rclk edge with rinc=1.
- flush  input  1  single-cycle pulse requesting emission of the partial word.
- o_valid  output  1  packed word valid.
- o_ready  input  1  downstream accept.
- o_data  output  DSIZE*RATIO  packed word; word k of the group sits in bits [k*DSIZE +: DSIZE], first popped word in the LSBs.
- o_cnt  output  CW  number of valid lanes in o_data (1..RATIO).

Behaviour:
- Reset (rrst=1, async): o_valid=0, o_data=0, o_cnt=0, lane counter cnt=0, accumulator=0, flush_pend=0, state=ACCUM. rinc is combinational and is 0 while in reset.
- Output register is free when o_valid=0 or o_ready=1 in the same cycle.
- Transfer occurs on the edge where o_valid=1 and o_ready=1. o_valid drops unless a new word loads the same edge.
- o_data and o_cnt stay stable while o_valid=1 and o_ready=0.
- State ACCUM:
  - rinc = !rempty && !flush_pend && !(cnt==RATIO-1 && !out_free).
  - On a pop with cnt<RATIO-1: store rdata in lane cnt, cnt += 1.
  - On a pop with cnt==RATIO-1: load o_data = {rdata, lanes RATIO-2..0}, o_cnt=RATIO, o_valid=1, cnt=0, accumulator cleared.
  - Latency: the completing pop is at edge n; o_valid=1 is visible after edge n.
  - Back-to-back packed words are allowed at full throughput when o_ready is held high.
- Flush:
  - flush=1 sets flush_pend on the next edge. Pops already qualified in that same cycle still occur.
  - A flush that arrives while flush_pend=1 is absorbed.
  - In ACCUM with flush_pend=1, go to FLUSH; rinc=0 while in FLUSH.
- State FLUSH:
  - If cnt==0: clear flush_pend, return to ACCUM, emit nothing.
  - Else, when out_free: load o_data = accumulator (unused upper lanes 0), o_cnt=cnt, o_valid=1, cnt=0, clear flush_pend, return to ACCUM.
  - Else hold until the output register is free.
- Simultaneous flush and a completing pop: the full word is emitted first (o_cnt=RATIO). Flush then finds cnt==0 and emits nothing.
- rempty=1: rinc=0 and no state change, except flush handling.
- Counters wrap only by explicit clear; cnt never exceeds RATIO-1.
- rinc is never asserted when rempty=1; the bench checks this on every cycle.
- Reset mid-packet discards the accumulator and any pending output. No partial word is emitted after reset deasserts.

Test Plan:
- Reset: assert rrst async mid-cycle with rempty=0 -> rinc=0, o_valid=0, o_cnt=0, o_data=0 immediately.
- Basic pack (DSIZE=8, RATIO=4): FIFO holds 0x11,0x22,0x33,0x44, o_ready=1.
  - Expect 4 consecutive rinc pulses, then o_valid=1 with o_data=0x44332211 and o_cnt=4 one edge after the 4th pop.
- Backpressure: 8 words 0x01..0x08 with o_ready=0.
  - Expect the first packed word 0x04030201 held stable; pops stop after word 0x07 (cnt==3, output busy).
  - Raise o_ready -> 0x04030201 accepted, 0x08 popped, then 0x08070605 emitted.
- Partial flush: pop 0xAA,0xBB, then pulse flush with rempty=1 -> o_data=0x0000BBAA, o_cnt=2, o_valid=1; cnt returns to 0.
- Flush while empty, and flush coincident with the 4th pop -> the first emits nothing; the second emits exactly one word with o_cnt=4 and no extra zero-count word.
- Random stress with a reference model:
  - Random rempty/o_ready/flush over 10k cycles; concatenated output lanes (per o_cnt) equal the popped sequence.
  - rinc&&rempty never observed.
